// File: rtl/motor_dir_sequencer_if.sv
// Command and drive signals between the operator controls and the motor direction sequencer.
interface motor_dir_sequencer_if;
    logic       cmd_on;
    logic       cmd_reverse;
    logic [3:0] cmd_speed;
    logic       motor_on;
    logic       motor_reverse;
    logic [1:0] state;
    logic       busy;

    modport master (
        output cmd_on, cmd_reverse, cmd_speed,
        input  motor_on, motor_reverse, state, busy
    );

    modport slave (
        input  cmd_on, cmd_reverse, cmd_speed,
        output motor_on, motor_reverse, state, busy
    );
endinterface

// File: rtl/motor_dir_sequencer.sv
// H-bridge run/direction sequencer: enforces dead time between stops and reversals, with a 16-step PWM.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | drive off, waiting for a run request
// RUN   | drive enabled (PWM-gated) in the latched direction
// DEAD  | drive held off for DEADTIME cycles before any restart
module motor_dir_sequencer #(
    parameter int DEADTIME = 50000,
    parameter int PWM_DIV  = 256
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    motor_dir_sequencer_if.slave  bus
);

    localparam int PS_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int DT_W = $clog2(DEADTIME);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              on_m, on_s, rev_m, rev_s;
    logic [3:0]        spd_m, spd_s;
    logic [PS_W-1:0]   presc_q;
    logic [3:0]        step_q;
    logic [3:0]        duty_q;
    logic              wrap;
    logic              pwm;
    logic [DT_W-1:0]   dead_cnt_q;
    logic              dead_done;
    logic              dir_q, dir_d;
    logic              motor_on_q, motor_on_d;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            on_m  <= 1'b0;
            on_s  <= 1'b0;
            rev_m <= 1'b0;
            rev_s <= 1'b0;
            spd_m <= 4'd0;
            spd_s <= 4'd0;
        end else begin
            on_m  <= bus.cmd_on;
            on_s  <= on_m;
            rev_m <= bus.cmd_reverse;
            rev_s <= rev_m;
            spd_m <= bus.cmd_speed;
            spd_s <= spd_m;
        end
    end

    assign wrap = (presc_q == PS_W'(PWM_DIV - 1));

    // Duty only changes at the period boundary so a PWM period is never truncated.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            step_q  <= 4'd0;
            duty_q  <= 4'd0;
        end else if (wrap) begin
            presc_q <= '0;
            step_q  <= step_q + 4'd1;
            if (step_q == 4'd15) begin
                duty_q <= spd_s;
            end
        end else begin
            presc_q <= presc_q + PS_W'(1);
        end
    end

    assign pwm       = (duty_q == 4'd15) || (step_q < duty_q);
    assign dead_done = (dead_cnt_q == DT_W'(DEADTIME - 1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            motor_on_q <= 1'b0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            motor_on_q <= motor_on_d;
            if ((state_q == DEAD) && (state_d == DEAD)) begin
                dead_cnt_q <= dead_cnt_q + DT_W'(1);
            end else begin
                dead_cnt_q <= '0;
            end
        end
    end

    // Enable is only granted while staying in RUN, so the cycle in which the
    // direction changes (entry into RUN) always has the drive off.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        motor_on_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (on_s) begin
                    state_d = RUN;
                    dir_d   = rev_s;
                end
            end
            RUN: begin
                if (!on_s || (rev_s != dir_q)) begin
                    state_d = DEAD;
                end else begin
                    motor_on_d = pwm;
                end
            end
            DEAD: begin
                if (dead_done) begin
                    if (on_s) begin
                        state_d = RUN;
                        dir_d   = rev_s;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.motor_on      = motor_on_q;
    assign bus.motor_reverse = dir_q;
    assign bus.state         = state_q;
    assign bus.busy          = (state_q == DEAD);

endmodule

// File: doc/motor_dir_sequencer.md
MOTOR_DIR_SEQUENCER -- requirements
Module: motor_dir_sequencer

Interface
REQ-001 Parameter DEADTIME, default 50000: clock cycles motor drive is held off before any restart after a stop or direction change (min 2).
REQ-002 Parameter PWM_DIV, default 256: clock cycles per PWM step (min 1).
REQ-003 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 cmd_on  input  1  requested run (switch level, asynchronous to CLOCK_50).
REQ-006 cmd_reverse  input  1  requested direction, 1 = reverse (asynchronous).
REQ-007 cmd_speed  input  4  requested duty, 0..15 (asynchronous).
REQ-008 motor_on  output  1  registered H-bridge enable (PWM-gated), feeds the GPIO driver stage.
REQ-009 motor_reverse  output  1  registered direction to the GPIO driver stage.
REQ-010 state  output  2  current FSM state for LED display: 00 IDLE, 01 RUN, 10 DEAD.
REQ-011 busy  output  1  1 while in DEAD.

Function
REQ-012 cmd_on, cmd_reverse, cmd_speed SHALL each pass through a 2-flop synchronizer; FSM and PWM use only synchronized copies (on_s, rev_s, spd_s).
REQ-013 A prescaler SHALL count 0..PWM_DIV-1 and wrap; on wrap a 4-bit step counter SHALL increment modulo 16; both free-run in every state.
REQ-014 Active duty duty_q SHALL load spd_s only when prescaler wraps and step == 15 (period boundary); no mid-period change.
REQ-015 pwm = 1 when duty_q == 15, else pwm = (step < duty_q); duty 0 gives constant 0.
REQ-016 IDLE: motor_on = 0; if on_s = 1, latch dir_q <= rev_s and go RUN next cycle.
REQ-017 RUN: motor_on = pwm (registered, one cycle after pwm), motor_reverse = dir_q.
REQ-018 RUN -> DEAD when on_s = 0 or rev_s != dir_q; dead counter cleared to 0 on entry.
REQ-019 DEAD: motor_on = 0, motor_reverse holds dir_q; counter increments each cycle.
REQ-020 DEAD exit when counter == DEADTIME-1: if on_s = 1, dir_q <= rev_s and go RUN; else go IDLE.
REQ-021 Command changes during DEAD SHALL NOT shorten or restart the dead time; only on_s/rev_s values at exit matter.
REQ-022 on_s and direction change in same cycle while RUN: single transition to DEAD.
REQ-023 motor_reverse SHALL change only on IDLE->RUN or DEAD->RUN transitions, never while motor_on = 1.
REQ-024 motor_on SHALL never be 1 in a cycle where motor_reverse differs from its previous-cycle value.
REQ-025 Latency cmd_on rising to first possible motor_on = 1 from IDLE: 2 sync + 1 FSM + 1 output register = 4 cycles (pwm permitting).

Reset
REQ-026 resetn = 0 SHALL immediately force: state IDLE, motor_on 0, motor_reverse 0, busy 0, dir_q 0, prescaler 0, step 0, duty_q 0, dead counter 0, all synchronizer flops 0.
REQ-027 Reset asserted mid-RUN or mid-DEAD SHALL drop motor_on within the same cycle (asynchronously); after release the block starts in IDLE with no dead time owed.
REQ-028 Block SHALL leave reset on the first CLOCK_50 edge after resetn rises, no extra settle cycles.

Verification (DEADTIME=8, PWM_DIV=2)
REQ-029 cmd_speed=15, cmd_reverse=0, cmd_on 0->1 from IDLE -> motor_on = 1 exactly 4 cycles later and stays 1; state=01, motor_reverse=0.
REQ-030 RUN at speed 15, flip cmd_reverse to 1 -> motor_on = 0 within 4 cycles, busy=1 for exactly 8 cycles, then motor_reverse=1 and motor_on=1 the following cycle; motor_reverse never toggles while motor_on=1.
REQ-031 cmd_speed=4 in RUN -> after next period boundary motor_on high 8 of every 32 cycles (4 steps x 2), contiguous at period start; cmd_speed=0 -> motor_on constant 0 while state stays 01.
REQ-032 During DEAD toggle cmd_on 1->0->1 and cmd_reverse twice -> DEAD length still 8 cycles; exit direction equals cmd_reverse value sampled at exit.
REQ-033 RUN, cmd_on 1->0 -> DEAD 8 cycles -> IDLE (state=00), motor_on 0, motor_reverse unchanged.
REQ-034 Pulse resetn low mid-DEAD -> motor_on, busy, state all 0 without a clock edge; after release, cmd_on=1 gives motor_on=1 at 4 cycles with no dead time.
